// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle between the two result sources, the register-file write port
// and decode's hazard query; the arbiter takes the slave side.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  a_valid;
  logic                  a_ready;
  logic [ADDR_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_reg;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0] ctrl_writeReg;
  logic [DATA_WIDTH-1:0] data_writeReg;
  logic [ADDR_WIDTH-1:0] ctrl_readRegA;
  logic [ADDR_WIDTH-1:0] ctrl_readRegB;
  logic                  hazard_A;
  logic                  hazard_B;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data, ctrl_readRegA, ctrl_readRegB,
    input  a_ready, b_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, hazard_A, hazard_B
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, ctrl_readRegA, ctrl_readRegB,
    output a_ready, b_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, hazard_A, hazard_B
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU writeback (A) and
// mul/div (B) using one-entry buffers and a round-robin drain to a registered port.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic clock,
  input  logic ctrl_reset,
  regfile_wb_arbiter_if.slave bus
);
  logic                  r_full_a, r_full_b;
  logic [ADDR_WIDTH-1:0] r_reg_a, r_reg_b;
  logic [DATA_WIDTH-1:0] r_data_a, r_data_b;
  logic                  r_rr;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_wreg;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic w_grant_a, w_grant_b;
  logic w_ready_a, w_ready_b;
  logic w_accept_a, w_accept_b;

  // Grants depend only on buffer state, so ready never combinationally follows valid.
  assign w_grant_a  = r_full_a & (~r_full_b | ~r_rr);
  assign w_grant_b  = r_full_b & (~r_full_a | r_rr);
  assign w_ready_a  = ~r_full_a | w_grant_a;
  assign w_ready_b  = ~r_full_b | w_grant_b;
  assign w_accept_a = bus.a_valid & w_ready_a;
  assign w_accept_b = bus.b_valid & w_ready_b;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_full_a <= 1'b0;
      r_full_b <= 1'b0;
      r_reg_a  <= '0;
      r_reg_b  <= '0;
      r_data_a <= '0;
      r_data_b <= '0;
      r_rr     <= 1'b0;
      r_we     <= 1'b0;
      r_wreg   <= '0;
      r_wdata  <= '0;
    end else begin
      if (w_grant_a) begin
        r_we    <= 1'b1;
        r_wreg  <= r_reg_a;
        r_wdata <= r_data_a;
        r_rr    <= 1'b1;
      end else if (w_grant_b) begin
        r_we    <= 1'b1;
        r_wreg  <= r_reg_b;
        r_wdata <= r_data_b;
        r_rr    <= 1'b0;
      end else begin
        r_we <= 1'b0;
      end

      // A reload on the draining edge keeps the buffer full; writes to r0 are dropped.
      if (w_accept_a && (bus.a_reg != '0)) begin
        r_full_a <= 1'b1;
        r_reg_a  <= bus.a_reg;
        r_data_a <= bus.a_data;
      end else if (w_grant_a) begin
        r_full_a <= 1'b0;
      end

      if (w_accept_b && (bus.b_reg != '0)) begin
        r_full_b <= 1'b1;
        r_reg_b  <= bus.b_reg;
        r_data_b <= bus.b_data;
      end else if (w_grant_b) begin
        r_full_b <= 1'b0;
      end
    end
  end

  assign bus.a_ready          = w_ready_a;
  assign bus.b_ready          = w_ready_b;
  assign bus.ctrl_writeEnable = r_we;
  assign bus.ctrl_writeReg    = r_wreg;
  assign bus.data_writeReg    = r_wdata;

  // A read index has a hazard while any buffered or in-flight write targets it.
  assign bus.hazard_A = (bus.ctrl_readRegA != '0) &
                        ((r_full_a & (r_reg_a == bus.ctrl_readRegA)) |
                         (r_full_b & (r_reg_b == bus.ctrl_readRegA)) |
                         (r_we & (r_wreg == bus.ctrl_readRegA)));
  assign bus.hazard_B = (bus.ctrl_readRegB != '0) &
                        ((r_full_a & (r_reg_a == bus.ctrl_readRegB)) |
                         (r_full_b & (r_reg_b == bus.ctrl_readRegB)) |
                         (r_we & (r_wreg == bus.ctrl_readRegB)));
endmodule
